// File: rtl/avalon_ram_slave.sv
// avalon_ram_slave: Avalon-MM slave RAM for CPU fetch/load/store traffic.
// Each access waits WAIT_CYCLES cycles and honours byte enables.
// A side-band preload port writes whole words on any edge.
// Optional feature macro: RAM_OOR_TRAP_EN. When it is defined, addresses with
// nonzero bits above the index read as 32'hDEADBEEF and their writes are dropped.
module avalon_ram_slave #(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  // Request captured at acceptance; later bus changes do not affect it.
  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic              oor;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              is_rd;
  } req_t;

  logic [31:0] mem [DEPTH];

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  req_t hold;

  logic              req;
  logic              in_oor;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_oor;
  logic              acc_rd;

  assign req = read | write;

`ifdef RAM_OOR_TRAP_EN
  assign in_oor = |address[31:ADDR_W+2];
`else
  // Upper address bits alias onto the index.
  assign in_oor = 1'b0;
  logic unused_hi;
  assign unused_hi = &{1'b0, address[31:ADDR_W+2]};
`endif

  logic unused_lo;
  assign unused_lo = &{1'b0, address[1:0], load_addr[1:0]};

  // A one-wait-cycle access enters ACK straight from IDLE, so the read must
  // use the live bus fields on that edge rather than the holding register.
  assign acc_idx = (state == IDLE) ? address[ADDR_W+1:2] : hold.idx;
  assign acc_oor = (state == IDLE) ? in_oor : hold.oor;
  assign acc_rd  = (state == IDLE) ? read   : hold.is_rd;

  // State and wait counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. Dropping the request in WAIT abandons the access,
  // even on the edge that would otherwise move to ACK.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 1) begin
            state_nxt = ACK;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode for waitrequest.
  always_comb begin
    waitrequest = 1'b0;
    case (state)
      IDLE:    waitrequest = req;
      WAIT:    waitrequest = 1'b1;
      ACK:     waitrequest = 1'b0;
      default: waitrequest = 1'b0;
    endcase
  end

  // Capture the request at acceptance. Read wins when read and write are both high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= '0;
    end else if (state == IDLE && req) begin
      hold.idx   <= address[ADDR_W+1:2];
      hold.oor   <= in_oor;
      hold.wdata <= writedata;
      hold.be    <= byteenable;
      hold.is_rd <= read;
    end
  end

  // Load read data on the edge that enters ACK. Writes leave it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata <= 32'd0;
    end else if (state_nxt == ACK && acc_rd) begin
      readdata <= acc_oor ? 32'hDEADBEEF : mem[acc_idx];
    end
  end

  // Memory array, not reset. The bus write commits on the ACK->IDLE edge.
  // The preload is assigned last, so it fully overrides a same-word commit.
  always_ff @(posedge clk) begin
    if (state == ACK && !hold.is_rd && !hold.oor) begin
      for (int b = 0; b < 4; b++) begin
        if (hold.be[b]) mem[hold.idx][8*b +: 8] <= hold.wdata[8*b +: 8];
      end
    end
    if (load_en) mem[load_addr[ADDR_W+1:2]] <= load_data;
  end

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Directed bench for avalon_ram_slave (ADDR_W=6, WAIT_CYCLES=2).
module tb_avalon_ram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  int total = 0;
  int bad   = 0;

  avalon_ram_slave #(.ADDR_W(6), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one bus access and returns read data plus the count of waited cycles.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rdat, output int nw);
    bit done = 1'b0;
    nw = 0;
    @(posedge clk); #1;
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (waitrequest) nw++;
      else done = 1'b1;
    end
    rdat = readdata;
    total++;
    assert (done) else begin
      bad++;
      $error("FAIL handshake_timeout: observed waitrequest stuck %0d cycles expected release", nw);
    end
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int nw;
    reset = 1'b0; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; byteenable = '0; load_en = 1'b0; load_addr = '0; load_data = '0;

    // Reset state: readdata cleared, waitrequest follows read|write.
    #3;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_wait_idle", {31'd0, waitrequest}, 32'd0);
    read = 1'b1; #1;
    chk("rst_wait_req", {31'd0, waitrequest}, 32'd1);
    read = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    // Preload and basic read timing.
    preload(8'h04, 32'h24030FF0);
    preload(8'h08, 32'h386200FF);
    preload(8'h10, 32'h00000000);
    access(1'b1, 1'b0, 32'h08, 32'h0, 4'h0, rd, nw);
    chk("rd08_waits", nw, 32'd2);
    chk("rd08_data", rd, 32'h386200FF);
    access(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, rd, nw);
    chk("rd04_data", rd, 32'h24030FF0);

    // Byte-enable writes.
    access(1'b0, 1'b1, 32'h04, 32'hAABBCCDD, 4'b0011, rd, nw);
    chk("wr_be0011_waits", nw, 32'd2);
    access(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, rd, nw);
    chk("rd_after_be0011", rd, 32'h2403CCDD);
    access(1'b0, 1'b1, 32'h04, 32'hAABBCCDD, 4'b1000, rd, nw);
    access(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, rd, nw);
    chk("rd_after_be1000", rd, 32'hAA03CCDD);
    access(1'b0, 1'b1, 32'h04, 32'hFFFFFFFF, 4'b0000, rd, nw);
    chk("wr_be0000_waits", nw, 32'd2);
    access(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, rd, nw);
    chk("rd_after_be0000", rd, 32'hAA03CCDD);

    // Reset during WAIT of a write discards it and clears readdata.
    @(posedge clk); #1;
    write = 1'b1; address = 32'h10; writedata = 32'h12345678; byteenable = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("mid_wr_waitreq", {31'd0, waitrequest}, 32'd1);
    reset = 1'b0; #1;
    chk("mid_wr_rst_readdata", readdata, 32'h0);
    write = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, nw);
    chk("rd10_after_rst", rd, 32'h0);

    // Read and write together behave as a read.
    access(1'b1, 1'b1, 32'h04, 32'h11111111, 4'hF, rd, nw);
    chk("rdwr_data", rd, 32'hAA03CCDD);
    access(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, rd, nw);
    chk("rdwr_mem_kept", rd, 32'hAA03CCDD);

    // Drop a write mid-WAIT: no commit, and the FSM is back in IDLE.
    @(posedge clk); #1;
    write = 1'b1; address = 32'h04; writedata = 32'h55555555; byteenable = 4'hF;
    @(posedge clk); #1;
    write = 1'b0;
    access(1'b1, 1'b0, 32'h08, 32'h0, 4'h0, rd, nw);
    chk("drop_next_waits", nw, 32'd2);
    chk("drop_next_data", rd, 32'h386200FF);
    access(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, rd, nw);
    chk("drop_no_commit", rd, 32'hAA03CCDD);

    // Preload beats a same-word bus write on the commit edge.
    access(1'b0, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'hF, rd, nw);
    access(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, rd, nw);
    chk("wr0c_plain", rd, 32'hFFFFFFFF);
    fork
      access(1'b0, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'hF, rd, nw);
      begin
        repeat (3) @(posedge clk);
        #1 load_en = 1'b1; load_addr = 8'h0C; load_data = 32'h00000008;
        @(posedge clk); #1 load_en = 1'b0;
      end
    join
    access(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, rd, nw);
    chk("preload_wins", rd, 32'h00000008);

    // Out-of-range addresses: trap or alias depending on build.
    access(1'b1, 1'b0, 32'h00000104, 32'h0, 4'h0, rd, nw);
    chk("oor_rd_waits", nw, 32'd2);
`ifdef RAM_OOR_TRAP_EN
    chk("oor_rd_data", rd, 32'hDEADBEEF);
`else
    chk("oor_rd_data", rd, 32'hAA03CCDD);
`endif
    access(1'b0, 1'b1, 32'h00000104, 32'h0, 4'hF, rd, nw);
    access(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, rd, nw);
`ifdef RAM_OOR_TRAP_EN
    chk("oor_wr_effect", rd, 32'hAA03CCDD);
`else
    chk("oor_wr_effect", rd, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/avalon_ram_slave.md
# avalon_ram_slave

Synthesisable Avalon-MM slave memory that serves the CPU's instruction fetches and data loads/stores over the `address/read/write/waitrequest/readdata` bus. It sits directly downstream of `top_level_CPU` and replaces the behavioural RAM in regression benches. The block inserts a programmable number of wait states, honours byte enables, and provides a side-band preload port so benches can write a program image before releasing the CPU.

## Interface
- `ADDR_W`, 6: word-index width; memory holds 2^ADDR_W 32-bit words, indexed by `address[ADDR_W+1:2]`.
- `WAIT_CYCLES`, 2: cycles `waitrequest` is held high per access; legal range 1..15.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `address`  in  32  byte address from CPU; bits [1:0] ignored.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  32  store data.
- `byteenable`  in  4  lane enables; bit n covers `writedata[8n+7:8n]`.
- `waitrequest`  out  1  high = request not yet accepted; master must hold request.
- `readdata`  out  32  read data; valid in the cycle `waitrequest` is low after a read.
- `load_en`  in  1  preload strobe; full-word write on the rising edge.
- `load_addr`  in  8  preload byte address; bits [1:0] ignored.
- `load_data`  in  32  preload word.

## Operation
- FSM states: IDLE, WAIT, ACK. Counter `cnt` is 4 bits.
- IDLE: `waitrequest` = `read | write` (combinational). On an edge with a request: latch address, writedata, byteenable, and op into holding registers. If `WAIT_CYCLES` = 1, go to ACK; otherwise go to WAIT with `cnt` = `WAIT_CYCLES` − 1.
- WAIT: `waitrequest` = 1. Decrement `cnt`; go to ACK on the edge where `cnt` = 1.
- Entry to ACK (same edge): for a read, `readdata` <= mem[latched index].
- ACK: `waitrequest` = 0. For a write, commit the latched bytes whose enable is set on the ACK→IDLE edge. Always return to IDLE.
- Inputs that change after latching are ignored until the next IDLE.
- Request dropped (both `read` and `write` low) while in WAIT: abandon on that edge and go to IDLE. No write is committed and `readdata` is unchanged.
- `read` and `write` both high: treat as a read; the write is discarded.
- `byteenable` = 0000 on a write: full handshake completes, no memory change.
- Preload: `load_en` writes mem[`load_addr[ADDR_W+1:2]`] on any edge, in any FSM state. If it hits the same word as an ACK-edge bus write, the preload wins entirely.
- Memory contents are not reset. Power-up contents are X.

## Timing
- Reset (async assert): state = IDLE, `cnt` = 0, `readdata` = 0, holding registers = 0. `waitrequest` then follows `read | write`. Any pending write is discarded.
- Request first visible in cycle 0 → `waitrequest` high in cycles 0..`WAIT_CYCLES`−1, low in cycle `WAIT_CYCLES`.
- Read data is valid during cycle `WAIT_CYCLES`. A write is visible to a read that accepts in any later cycle.
- Throughput: one access per `WAIT_CYCLES` + 1 cycles. A back-to-back request is first seen in the IDLE cycle after ACK.
- Address wrap-around: index uses only `ADDR_W` bits; higher bits alias unless the macro below is defined.

## Configuration
- `RAM_OOR_TRAP_EN` defined: any address with nonzero bits above `ADDR_W+1`:
  - reads return 32'hDEADBEEF;
  - writes are dropped;
  - handshake timing is unchanged.
- Not defined: upper address bits are ignored and addresses alias.
- The preload port always aliases in both configurations.

## Test plan
- Preload: 0x04 = 0x24030FF0, 0x08 = 0x386200FF. Read 0x08 with `WAIT_CYCLES` = 2 -> `waitrequest` high for 2 cycles, then low with `readdata` = 0x386200FF.
- Word 0x04 = 0x24030FF0. Write 0xAABBCCDD with `byteenable` = 0011 -> read of 0x04 returns 0x2403CCDD. Then write with `byteenable` = 1000 -> 0xAA03CCDD.
- Assert `reset` low during the WAIT of a write of 0x12345678 to 0x10 (preloaded 0) -> after reset, `readdata` = 0 and a read of 0x10 returns 0.
- Issue `read` and `write` together at 0x04 -> `readdata` = stored word, memory unchanged. Then drop `write` mid-WAIT -> no commit, FSM in IDLE next cycle.
- Preload 0x0C = 0x00000008 on the same edge as a bus write of 0xFFFFFFFF to 0x0C -> read returns 0x00000008.
- With `RAM_OOR_TRAP_EN` and `ADDR_W` = 6, read 0x00000104 -> 0xDEADBEEF. Without the macro -> returns the word at 0x04.
